snake_dir_queue: RTL and testbench

- Sits between the PS/2 keyboard receiver and snake_field.
- Turns raw set-2 scancode bytes into start/pause pulses and a buffered, reversal-filtered snake direction.
- The queue absorbs fast key presses between game ticks. One entry is applied per snake step, so quick turn sequences (e.g. up then left within one tick) are never lost or collapsed into an illegal reversal.

---
 rtl/snake_dir_queue.sv | 208 ++++++++++++++++++++
 tb/tb_snake_dir_queue.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snake_dir_queue.sv
// snake_dir_queue: PS/2 set-2 scancode front end for the snake game.
// Decodes E0/F0 prefixes and turns the Enter and Space makes into one-cycle
// start/pause pulses. Arrow-key makes are turned into a small FIFO of
// direction changes. A push is dropped if it repeats or reverses the
// direction it would follow. One entry is applied per snake step.
//
// Optional build macro: SNAKE_WASD_EN. When it is defined, the W/D/S/A
// normal makes (1D/23/1B/1C) steer the snake just like the arrow keys.
//
// Ports:
//   clk          system clock
//   rst          asynchronous reset, active-high
//   key          scancode byte from the keyboard receiver
//   key_pressed  one-cycle strobe, key valid this cycle
//   step         one-cycle snake move strobe
//   start        one-cycle pulse after an Enter make
//   pause        one-cycle pulse after a Space make
//   snake_dir    applied direction (0 up, 1 right, 2 down, 3 left)
//   queue_level  number of pending direction entries
module snake_dir_queue #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [1:0]  INIT_DIR = 2'd1
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [7:0]                     key,
   input  logic                           key_pressed,
   input  logic                           step,
   output logic                           start,
   output logic                           pause,
   output logic [1:0]                     snake_dir,
   output logic [$clog2(DEPTH+1)-1:0]     queue_level
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned LVL_W = $clog2(DEPTH + 1);

   localparam logic [7:0] KEY_EXT   = 8'hE0;
   localparam logic [7:0] KEY_BRK   = 8'hF0;
   localparam logic [7:0] KEY_ENTER = 8'h5A;
   localparam logic [7:0] KEY_SPACE = 8'h29;
   localparam logic [7:0] KEY_UP    = 8'h75;
   localparam logic [7:0] KEY_RIGHT = 8'h74;
   localparam logic [7:0] KEY_DOWN  = 8'h72;
   localparam logic [7:0] KEY_LEFT  = 8'h6B;
`ifdef SNAKE_WASD_EN
   localparam logic [7:0] KEY_W     = 8'h1D;
   localparam logic [7:0] KEY_D     = 8'h23;
   localparam logic [7:0] KEY_S     = 8'h1B;
   localparam logic [7:0] KEY_A     = 8'h1C;
`endif

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      EXT     = 2'd1,
      BRK     = 2'd2,
      EXT_BRK = 2'd3
   } pfx_state_t;

   pfx_state_t             state_q, state_d;
   logic [1:0]             mem_q [DEPTH];
   logic [1:0]             mem_d [DEPTH];
   logic [PTR_W-1:0]       head_q, head_d;
   logic [PTR_W-1:0]       tail_q, tail_d;
   logic [LVL_W-1:0]       level_q, level_d;
   logic [1:0]             dir_q, dir_d;
   logic                   start_q, start_d;
   logic                   pause_q, pause_d;

   logic                   norm_make;
   logic                   ext_make;
   logic                   start_ev;
   logic                   pause_ev;
   logic                   dir_vld;
   logic [1:0]             dir_new;
   logic [1:0]             ref_dir;
   logic                   q_empty;
   logic                   q_full;
   logic                   do_push;
   logic                   do_pop;

   // Prefix FSM: state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Prefix FSM: next state and make classification
   always_comb begin
      state_d   = state_q;
      norm_make = 1'b0;
      ext_make  = 1'b0;
      if (key_pressed) begin
         case (state_q)
            IDLE: begin
               if (key == KEY_EXT)      state_d = EXT;
               else if (key == KEY_BRK) state_d = BRK;
               else                     norm_make = 1'b1;
            end
            EXT: begin
               if (key == KEY_BRK)      state_d = EXT_BRK;
               else if (key == KEY_EXT) state_d = EXT;
               else begin
                  ext_make = 1'b1;
                  state_d  = IDLE;
               end
            end
            // Byte after a break prefix is a release code: drop it
            default: state_d = IDLE;
         endcase
      end
   end

   // Make code decode
   always_comb begin
      start_ev = 1'b0;
      pause_ev = 1'b0;
      dir_vld  = 1'b0;
      dir_new  = 2'd0;
      if (norm_make) begin
         case (key)
            KEY_ENTER: start_ev = 1'b1;
            KEY_SPACE: pause_ev = 1'b1;
`ifdef SNAKE_WASD_EN
            KEY_W: begin dir_vld = 1'b1; dir_new = 2'd0; end
            KEY_D: begin dir_vld = 1'b1; dir_new = 2'd1; end
            KEY_S: begin dir_vld = 1'b1; dir_new = 2'd2; end
            KEY_A: begin dir_vld = 1'b1; dir_new = 2'd3; end
`endif
            default: ;
         endcase
      end
      if (ext_make) begin
         case (key)
            KEY_UP:    begin dir_vld = 1'b1; dir_new = 2'd0; end
            KEY_RIGHT: begin dir_vld = 1'b1; dir_new = 2'd1; end
            KEY_DOWN:  begin dir_vld = 1'b1; dir_new = 2'd2; end
            KEY_LEFT:  begin dir_vld = 1'b1; dir_new = 2'd3; end
            default: ;
         endcase
      end
   end

   // Direction queue: filter against the direction the new entry would follow
   always_comb begin
      q_empty = (level_q == '0);
      q_full  = (level_q == LVL_W'(DEPTH));
      ref_dir = q_empty ? dir_q : mem_q[tail_q - PTR_W'(1)];
      do_pop  = step && !q_empty;
      // A full queue can still take a push when a pop frees a slot this cycle
      do_push = dir_vld && (dir_new != ref_dir) && (dir_new != (ref_dir ^ 2'b10))
                && (!q_full || step);

      mem_d   = mem_q;
      head_d  = head_q;
      tail_d  = tail_q;
      level_d = level_q;
      dir_d   = dir_q;
      start_d = start_ev;
      pause_d = pause_ev;

      if (start_ev) begin
         // New game: flush everything, ignoring any coincident step
         head_d  = '0;
         tail_d  = '0;
         level_d = '0;
         dir_d   = INIT_DIR;
      end else begin
         if (do_pop) begin
            dir_d  = mem_q[head_q];
            head_d = head_q + PTR_W'(1);
         end
         if (do_push) begin
            mem_d[tail_q] = dir_new;
            tail_d        = tail_q + PTR_W'(1);
         end
         if (do_push && !do_pop)      level_d = level_q + LVL_W'(1);
         else if (do_pop && !do_push) level_d = level_q - LVL_W'(1);
      end
   end

   // Queue and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= 2'd0;
         head_q  <= '0;
         tail_q  <= '0;
         level_q <= '0;
         dir_q   <= INIT_DIR;
         start_q <= 1'b0;
         pause_q <= 1'b0;
      end else begin
         mem_q   <= mem_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         level_q <= level_d;
         dir_q   <= dir_d;
         start_q <= start_d;
         pause_q <= pause_d;
      end
   end

   assign start       = start_q;
   assign pause       = pause_q;
   assign snake_dir   = dir_q;
   assign queue_level = level_q;

endmodule

// File: tb/tb_snake_dir_queue.sv
// Self-checking bench for snake_dir_queue: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_snake_dir_queue;

   localparam int unsigned DEPTH    = 4;
   localparam logic [1:0]  INIT_DIR = 2'd1;
   localparam int unsigned LVL_W    = $clog2(DEPTH + 1);

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic [7:0]       key = 8'h00;
   logic             key_pressed = 1'b0;
   logic             step = 1'b0;
   logic             start;
   logic             pause;
   logic [1:0]       snake_dir;
   logic [LVL_W-1:0] queue_level;

   int checks = 0;
   int errors = 0;

   // Reference model state
   int         m_q[$];
   int         m_dir;
   bit         m_start;
   bit         m_pause;
   int         m_pfx;   // 0 none, 1 seen E0, 2 seen F0, 3 seen E0 F0

   snake_dir_queue #(.DEPTH(DEPTH), .INIT_DIR(INIT_DIR)) dut (
      .clk         (clk),
      .rst         (rst),
      .key         (key),
      .key_pressed (key_pressed),
      .step        (step),
      .start       (start),
      .pause       (pause),
      .snake_dir   (snake_dir),
      .queue_level (queue_level)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_q.delete();
      m_dir   = int'(INIT_DIR);
      m_start = 0;
      m_pause = 0;
      m_pfx   = 0;
   endtask

   // Apply one clock edge's worth of rules to the model
   task automatic model_edge(input logic [7:0] k, input bit kp, input bit st);
      bit nm = 0, em = 0, dv = 0, ok;
      int d = 0, r;
      m_start = 0;
      m_pause = 0;
      if (kp) begin
         if (m_pfx == 0) begin
            if (k == 8'hE0) m_pfx = 1;
            else if (k == 8'hF0) m_pfx = 2;
            else nm = 1;
         end else if (m_pfx == 1) begin
            if (k == 8'hF0) m_pfx = 3;
            else if (k != 8'hE0) begin em = 1; m_pfx = 0; end
         end else m_pfx = 0;
      end
      if (em) begin
         if (k == 8'h75) begin dv = 1; d = 0; end
         if (k == 8'h74) begin dv = 1; d = 1; end
         if (k == 8'h72) begin dv = 1; d = 2; end
         if (k == 8'h6B) begin dv = 1; d = 3; end
      end
`ifdef SNAKE_WASD_EN
      if (nm) begin
         if (k == 8'h1D) begin dv = 1; d = 0; end
         if (k == 8'h23) begin dv = 1; d = 1; end
         if (k == 8'h1B) begin dv = 1; d = 2; end
         if (k == 8'h1C) begin dv = 1; d = 3; end
      end
`endif
      if (nm && k == 8'h29) m_pause = 1;
      if (nm && k == 8'h5A) begin
         m_start = 1;
         m_q.delete();
         m_dir = int'(INIT_DIR);
      end else begin
         r  = (m_q.size() > 0) ? m_q[$] : m_dir;
         ok = dv && d != r && d != (r ^ 2) && (m_q.size() < int'(DEPTH) || st);
         if (st && m_q.size() > 0) m_dir = m_q.pop_front();
         if (ok) m_q.push_back(d);
      end
   endtask

   // Drive one cycle of inputs, advance the model, return #1 after the edge
   task automatic drive(input logic [7:0] k, input bit kp, input bit st);
      @(negedge clk);
      key = k;
      key_pressed = kp;
      step = st;
      @(posedge clk);
      model_edge(k, kp, st);
      #1;
      key_pressed = 1'b0;
      step = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      key_pressed = 1'b0;
      step = 1'b0;
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      drive(8'hE0, 1, 0);
      drive(8'h75, 1, 0);
      // Asynchronous reset with a non-empty queue
      @(negedge clk);
      rst = 1'b1;
      #1;
      checks++;
      if (queue_level !== '0 || snake_dir !== INIT_DIR || start !== 1'b0 || pause !== 1'b0) begin
         $display("FAIL reset_async level=%0d dir=%0d start=%0b pause=%0b required 0/%0d/0/0",
                  queue_level, snake_dir, start, pause, INIT_DIR);
         errors++;
      end
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_start();
      drive(8'h5A, 1, 0);
      checks++;
      if (start !== 1'b1 || snake_dir !== 2'd1 || queue_level !== '0) begin
         $display("FAIL start_pulse start=%0b dir=%0d level=%0d required 1/1/0", start, snake_dir, queue_level);
         errors++;
      end
      drive(8'h00, 0, 0);
      checks++;
      if (start !== 1'b0) begin
         $display("FAIL start_one_cycle start=%0b required 0", start);
         errors++;
      end
      drive(8'h29, 1, 0);
      checks++;
      if (pause !== 1'b1 || start !== 1'b0) begin
         $display("FAIL pause_pulse pause=%0b start=%0b required 1/0", pause, start);
         errors++;
      end
   endtask

   task automatic test_queue_order();
      drive(8'hE0, 1, 0); drive(8'h75, 1, 0);
      drive(8'hE0, 1, 0); drive(8'h6B, 1, 0);
      checks++;
      if (queue_level !== LVL_W'(2)) begin
         $display("FAIL queue_two level=%0d required 2", queue_level);
         errors++;
      end
      drive(8'h00, 0, 1);
      checks++;
      if (snake_dir !== 2'd0 || queue_level !== LVL_W'(1)) begin
         $display("FAIL pop_first dir=%0d level=%0d required 0/1", snake_dir, queue_level);
         errors++;
      end
      drive(8'h00, 0, 1);
      checks++;
      if (snake_dir !== 2'd3 || queue_level !== '0) begin
         $display("FAIL pop_second dir=%0d level=%0d required 3/0", snake_dir, queue_level);
         errors++;
      end
      drive(8'h00, 0, 1);
      checks++;
      if (snake_dir !== 2'd3 || queue_level !== '0) begin
         $display("FAIL pop_empty dir=%0d level=%0d required 3/0", snake_dir, queue_level);
         errors++;
      end
   endtask

   task automatic test_reversal_filter();
      drive(8'h5A, 1, 0);   // back to right
      drive(8'hE0, 1, 0); drive(8'h6B, 1, 0);
      drive(8'hE0, 1, 0); drive(8'h74, 1, 0);
      checks++;
      if (queue_level !== '0 || snake_dir !== 2'd1) begin
         $display("FAIL reverse_repeat level=%0d dir=%0d required 0/1", queue_level, snake_dir);
         errors++;
      end
      drive(8'hE0, 1, 0); drive(8'hF0, 1, 0); drive(8'h75, 1, 0);
      checks++;
      if (queue_level !== '0) begin
         $display("FAIL break_no_push level=%0d required 0", queue_level);
         errors++;
      end
   endtask

   task automatic test_full();
      for (int i = 0; i < 4; i++) begin
         drive(8'hE0, 1, 0);
         drive((i % 2 == 0) ? 8'h75 : 8'h74, 1, 0);
      end
      checks++;
      if (queue_level !== LVL_W'(4)) begin
         $display("FAIL fill level=%0d required 4", queue_level);
         errors++;
      end
      drive(8'hE0, 1, 0); drive(8'h75, 1, 0);
      checks++;
      if (queue_level !== LVL_W'(4) || snake_dir !== 2'd1) begin
         $display("FAIL full_drop level=%0d dir=%0d required 4/1", queue_level, snake_dir);
         errors++;
      end
      drive(8'hE0, 1, 0); drive(8'h75, 1, 1);
      checks++;
      if (queue_level !== LVL_W'(4) || snake_dir !== 2'd0) begin
         $display("FAIL full_push_pop level=%0d dir=%0d required 4/0", queue_level, snake_dir);
         errors++;
      end
      // Drain and confirm order: right, up, right, up
      for (int i = 0; i < 4; i++) begin
         drive(8'h00, 0, 1);
         checks++;
         if (snake_dir !== ((i % 2 == 0) ? 2'd1 : 2'd0)) begin
            $display("FAIL drain_%0d dir=%0d required %0d", i, snake_dir, (i % 2 == 0) ? 1 : 0);
            errors++;
         end
      end
   endtask

   task automatic test_start_flush();
      drive(8'hE0, 1, 0); drive(8'h74, 1, 0);   // dir is up: right accepted
      drive(8'hE0, 1, 0); drive(8'h72, 1, 0);   // then down
      checks++;
      if (queue_level !== LVL_W'(2)) begin
         $display("FAIL flush_setup level=%0d required 2", queue_level);
         errors++;
      end
      drive(8'h5A, 1, 1);
      checks++;
      if (queue_level !== '0 || snake_dir !== INIT_DIR || start !== 1'b1) begin
         $display("FAIL start_flush level=%0d dir=%0d start=%0b required 0/%0d/1",
                  queue_level, snake_dir, start, INIT_DIR);
         errors++;
      end
   endtask

   task automatic test_reset_mid_prefix();
      int exp_lvl;
      drive(8'hE0, 1, 0);
      do_reset();
      drive(8'h75, 1, 0);
      checks++;
      if (queue_level !== '0 || snake_dir !== INIT_DIR) begin
         $display("FAIL prefix_discard level=%0d dir=%0d required 0/%0d", queue_level, snake_dir, INIT_DIR);
         errors++;
      end
`ifdef SNAKE_WASD_EN
      exp_lvl = 1;
`else
      exp_lvl = 0;
`endif
      drive(8'h1D, 1, 0);
      checks++;
      if (queue_level !== LVL_W'(exp_lvl)) begin
         $display("FAIL wasd_w level=%0d required %0d", queue_level, exp_lvl);
         errors++;
      end
   endtask

   task automatic test_random();
      logic [7:0] pool [12] = '{8'hE0, 8'hE0, 8'hF0, 8'h75, 8'h74, 8'h72, 8'h6B,
                                8'h29, 8'h1D, 8'h23, 8'h1C, 8'h00};
      logic [7:0] k;
      bit kp, st;
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 199) == 0) begin
            do_reset();
         end
         if ($urandom_range(0, 39) == 0) k = 8'h5A;
         else if ($urandom_range(0, 9) == 0) k = 8'($urandom);
         else k = pool[$urandom_range(0, 11)];
         kp = ($urandom_range(0, 3) != 0);
         st = ($urandom_range(0, 4) == 0);
         drive(k, kp, st);
         checks++;
         if (queue_level !== LVL_W'(m_q.size()) || snake_dir !== 2'(m_dir)
             || start !== m_start || pause !== m_pause) begin
            $display("FAIL random_%0d level=%0d dir=%0d start=%0b pause=%0b required %0d/%0d/%0b/%0b",
                     n, queue_level, snake_dir, start, pause, m_q.size(), m_dir, m_start, m_pause);
            errors++;
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_start();
      test_queue_order();
      test_reversal_filter();
      test_full();
      test_start_flush();
      test_reset_mid_prefix();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
